// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: default bit timing and FSM state encoding,
// common to the receiver and transmitter.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/tx_serial_8n1_buf_if.sv
// Host-side byte handshake and serial line status of the 8N1 transmitter.
interface tx_serial_8n1_buf_if;
  import uart_pkg::*;

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Active;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );

endinterface

// File: rtl/tx_serial_8n1_buf.sv
// 8N1 UART transmitter, LSB first, idle high, with a one-entry holding
// register so consecutive frames leave back-to-back with no idle gap.
module tx_serial_8n1_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  tx_serial_8n1_buf_if.slave    tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic                 bit_end_c;
  logic                 accept_c;
  logic                 load_c;

  assign bit_end_c = (cnt_q == CNT_LAST);
  assign accept_c  = tx.i_Tx_DV && ready_q;

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      serial_q     <= 1'b1;
      ready_q      <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      serial_q     <= serial_d;
      ready_q      <= ready_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load_c       = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          state_d = START;
          load_c  = 1'b1;
        end
      end
      START: begin
        if (bit_end_c) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          done_d = 1'b1;
          if (hold_valid_q) begin
            state_d = START;
            load_c  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load and accept are mutually exclusive: ready is low while hold is full.
    if (load_c) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      cnt_d        = '0;
    end
    if (accept_c) begin
      hold_d       = tx.i_Tx_Byte;
      hold_valid_d = 1'b1;
    end

    ready_d  = !hold_valid_d;
    active_d = (state_d != IDLE);

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[idx_d];
      default: serial_d = 1'b1;
    endcase
  end

  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_tx_serial_8n1_buf.sv
// Self-checking bench for tx_serial_8n1_buf: exact waveform checks plus a
// mid-bit sampling receiver model decoding the serial line.
module tb_tx_serial_8n1_buf;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tx_serial_8n1_buf_if u_if ();

  tx_serial_8n1_buf #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .tx        (u_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_q[$];

  // Expected line level at cycle k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned k);
    int unsigned j;
    j = k / CPB;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  // Receiver model: detect the start edge, sample each bit in its middle.
  logic       mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
    end else if (!mon_busy) begin
      if (u_if.o_Tx_Serial === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == int'(CPB / 2)) begin
        n_checks++;
        if (u_if.o_Tx_Serial !== 1'b0)
          $display("FAIL rx_start_bit: got %b expected 0 at %0t", u_if.o_Tx_Serial, $time);
        else n_pass++;
      end else if (mon_cnt > int'(CPB / 2) && ((mon_cnt - int'(CPB / 2)) % int'(CPB)) == 0) begin
        int j;
        j = (mon_cnt - int'(CPB / 2)) / int'(CPB);
        if (j <= 8) begin
          mon_byte[j-1] = u_if.o_Tx_Serial;
        end else begin
          n_checks++;
          if (u_if.o_Tx_Serial !== 1'b1)
            $display("FAIL rx_stop_bit: got %b expected 1 at %0t", u_if.o_Tx_Serial, $time);
          else n_pass++;
          rx_q.push_back(mon_byte);
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    u_if.i_Tx_DV   = 1'b0;
    u_if.i_Tx_Byte = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL reset_serial: got %b expected 1", u_if.o_Tx_Serial); else n_pass++;
    if (u_if.o_Tx_Ready  !== 1'b1) $display("FAIL reset_ready: got %b expected 1", u_if.o_Tx_Ready);   else n_pass++;
    if (u_if.o_Tx_Active !== 1'b0) $display("FAIL reset_active: got %b expected 0", u_if.o_Tx_Active); else n_pass++;
    if (u_if.o_Tx_Done   !== 1'b0) $display("FAIL reset_done: got %b expected 0", u_if.o_Tx_Done);     else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL idle_serial: got %b expected 1", u_if.o_Tx_Serial); else n_pass++;
    if (u_if.o_Tx_Ready  !== 1'b1) $display("FAIL idle_ready: got %b expected 1", u_if.o_Tx_Ready);   else n_pass++;
  endtask

  // Single frame: latency, every cycle of the waveform, Active and Done.
  task automatic test_frame(input logic [7:0] b);
    @(negedge clk);
    n_checks++;
    if (u_if.o_Tx_Ready !== 1'b1) $display("FAIL frame_ready_idle: got %b expected 1", u_if.o_Tx_Ready); else n_pass++;
    u_if.i_Tx_DV   = 1'b1;
    u_if.i_Tx_Byte = b;
    @(posedge clk);
    #1;
    u_if.i_Tx_DV   = 1'b0;
    u_if.i_Tx_Byte = ~b;
    @(negedge clk);
    n_checks += 3;
    if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL frame_latency_serial: got %b expected 1", u_if.o_Tx_Serial); else n_pass++;
    if (u_if.o_Tx_Ready  !== 1'b0) $display("FAIL frame_hold_full_ready: got %b expected 0", u_if.o_Tx_Ready); else n_pass++;
    if (u_if.o_Tx_Active !== 1'b0) $display("FAIL frame_latency_active: got %b expected 0", u_if.o_Tx_Active); else n_pass++;
    for (int unsigned k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      if (k < FRAME) begin
        n_checks += 3;
        if (u_if.o_Tx_Serial !== exp_bit(b, k))
          $display("FAIL frame_serial byte=%02h cyc=%0d: got %b expected %b", b, k, u_if.o_Tx_Serial, exp_bit(b, k));
        else n_pass++;
        if (u_if.o_Tx_Active !== 1'b1) $display("FAIL frame_active cyc=%0d: got %b expected 1", k, u_if.o_Tx_Active); else n_pass++;
        if (u_if.o_Tx_Done   !== 1'b0) $display("FAIL frame_done_early cyc=%0d: got %b expected 0", k, u_if.o_Tx_Done); else n_pass++;
        if (k == 0) begin
          n_checks++;
          if (u_if.o_Tx_Ready !== 1'b1) $display("FAIL frame_ready_after_load: got %b expected 1", u_if.o_Tx_Ready); else n_pass++;
        end
      end else begin
        n_checks += 3;
        if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL frame_end_serial: got %b expected 1", u_if.o_Tx_Serial); else n_pass++;
        if (u_if.o_Tx_Active !== 1'b0) $display("FAIL frame_end_active: got %b expected 0", u_if.o_Tx_Active); else n_pass++;
        if (u_if.o_Tx_Done   !== 1'b1) $display("FAIL frame_done_pulse: got %b expected 1", u_if.o_Tx_Done);   else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (u_if.o_Tx_Done !== 1'b0) $display("FAIL frame_done_width: got %b expected 0", u_if.o_Tx_Done); else n_pass++;
  endtask

  // Second byte queued during the first frame's start bit follows with no gap.
  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  cur;
    int unsigned f;
    @(negedge clk);
    u_if.i_Tx_DV   = 1'b1;
    u_if.i_Tx_Byte = a;
    @(posedge clk);
    #1 u_if.i_Tx_DV = 1'b0;
    @(posedge clk);
    for (int unsigned k = 0; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (k < 2 * FRAME) begin
        f   = k / FRAME;
        cur = (f == 0) ? a : b;
        n_checks += 3;
        if (u_if.o_Tx_Serial !== exp_bit(cur, k % FRAME))
          $display("FAIL b2b_serial cyc=%0d: got %b expected %b", k, u_if.o_Tx_Serial, exp_bit(cur, k % FRAME));
        else n_pass++;
        if (u_if.o_Tx_Active !== 1'b1) $display("FAIL b2b_active cyc=%0d: got %b expected 1", k, u_if.o_Tx_Active); else n_pass++;
        if (u_if.o_Tx_Done !== (k == FRAME))
          $display("FAIL b2b_done cyc=%0d: got %b expected %b", k, u_if.o_Tx_Done, (k == FRAME));
        else n_pass++;
      end else begin
        n_checks += 2;
        if (u_if.o_Tx_Done   !== 1'b1) $display("FAIL b2b_done_second: got %b expected 1", u_if.o_Tx_Done);   else n_pass++;
        if (u_if.o_Tx_Active !== 1'b0) $display("FAIL b2b_end_active: got %b expected 0", u_if.o_Tx_Active); else n_pass++;
      end
      if (k == 0) begin
        u_if.i_Tx_DV   = 1'b1;
        u_if.i_Tx_Byte = b;
      end else if (k == 1) begin
        n_checks++;
        if (u_if.o_Tx_Ready !== 1'b0) $display("FAIL b2b_ready_full: got %b expected 0", u_if.o_Tx_Ready); else n_pass++;
        u_if.i_Tx_DV = 1'b0;
      end
      if (k >= 1) u_if.i_Tx_Byte = 8'($urandom);
    end
  endtask

  // Stream bytes while holding DV; a byte advances only on an accepting edge.
  task automatic stream_bytes(input logic [7:0] bytes[$], input int max_gap_pct, input string name);
    int   idx;
    int   base;
    int   cyc;
    int   bound;
    logic r;
    logic dv;
    idx   = 0;
    cyc   = 0;
    base  = rx_q.size();
    bound = bytes.size() * FRAME * 3 + 200;
    while (idx < bytes.size() && cyc < bound) begin
      @(negedge clk);
      dv = ($urandom_range(0, 99) >= max_gap_pct);
      u_if.i_Tx_DV   = dv;
      u_if.i_Tx_Byte = bytes[idx];
      r = u_if.o_Tx_Ready;
      @(posedge clk);
      #1;
      if (r && dv) begin
        idx++;
        n_checks++;
        if (u_if.o_Tx_Ready !== 1'b0) $display("FAIL %s_ready_after_accept: got %b expected 0", name, u_if.o_Tx_Ready); else n_pass++;
      end
      cyc++;
    end
    u_if.i_Tx_DV = 1'b0;
    cyc = 0;
    while (rx_q.size() < base + bytes.size() && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rx_q.size() < base + bytes.size())
      $display("FAIL %s_timeout: got %0d frames expected %0d", name, rx_q.size() - base, bytes.size());
    else n_pass++;
    for (int i = 0; i < bytes.size() && base + i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[base + i] !== bytes[i])
        $display("FAIL %s_byte[%0d]: got %02h expected %02h", name, i, rx_q[base + i], bytes[i]);
      else n_pass++;
    end
    repeat (2 * FRAME) @(negedge clk);
    n_checks++;
    if (rx_q.size() != base + bytes.size())
      $display("FAIL %s_frame_count: got %0d expected %0d", name, rx_q.size() - base, bytes.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes[$];
    bytes = '{8'h11, 8'h22, 8'h33};
    stream_bytes(bytes, 0, "backpressure");
  endtask

  // Reset asserted k_abort cycles into a frame: immediate idle, no residue.
  task automatic test_reset_mid(input logic [7:0] b, input int unsigned k_abort);
    int base;
    @(negedge clk);
    u_if.i_Tx_DV   = 1'b1;
    u_if.i_Tx_Byte = b;
    @(posedge clk);
    #1 u_if.i_Tx_DV = 1'b0;
    @(posedge clk);
    repeat (k_abort + 1) @(negedge clk);
    n_checks++;
    if (u_if.o_Tx_Serial !== exp_bit(b, k_abort))
      $display("FAIL rstmid_pre_serial: got %b expected %b", u_if.o_Tx_Serial, exp_bit(b, k_abort));
    else n_pass++;
    base = rx_q.size();
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL rstmid_serial: got %b expected 1", u_if.o_Tx_Serial); else n_pass++;
    if (u_if.o_Tx_Ready  !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", u_if.o_Tx_Ready);   else n_pass++;
    if (u_if.o_Tx_Active !== 1'b0) $display("FAIL rstmid_active: got %b expected 0", u_if.o_Tx_Active); else n_pass++;
    if (u_if.o_Tx_Done   !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", u_if.o_Tx_Done);     else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      n_checks += 2;
      if (u_if.o_Tx_Serial !== 1'b1) $display("FAIL rstmid_residual_serial cyc=%0d: got %b expected 1", k, u_if.o_Tx_Serial); else n_pass++;
      if (u_if.o_Tx_Active !== 1'b0) $display("FAIL rstmid_residual_active cyc=%0d: got %b expected 0", k, u_if.o_Tx_Active); else n_pass++;
    end
    n_checks++;
    if (rx_q.size() != base) $display("FAIL rstmid_frames: got %0d expected 0", rx_q.size() - base); else n_pass++;
  endtask

  task automatic test_loopback(input int n);
    logic [7:0] bytes[$];
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    stream_bytes(bytes, 25, "loopback");
  endtask

  initial begin
    u_if.i_Tx_DV   = 1'b0;
    u_if.i_Tx_Byte = 8'h00;
    test_reset();
    test_frame(8'h55);
    test_frame(8'h00);
    test_frame(8'($urandom));
    test_back_to_back(8'hA5, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_backpressure();
    test_reset_mid(8'hFF, 17);
    test_reset_mid(8'($urandom), 1);
    test_frame(8'($urandom));
    test_loopback(256);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
